// File: rtl/tratador_eventos_if.sv
// Bundle between the code-sequence FSM (master) and the event handler (slave):
// the state code goes in, the indications and status flags come back.
interface tratador_eventos_if;
   logic [3:0] estado;
   logic       led_acao;
   logic       led_hora;
   logic       alarme;
   logic       bloqueio;
   logic [2:0] falhas;
   logic       evento;
   logic [1:0] cod_evento;
   logic       cod_invalido;

   modport master (
      output estado,
      input  led_acao, led_hora, alarme, bloqueio, falhas, evento, cod_evento, cod_invalido
   );

   modport slave (
      input  estado,
      output led_acao, led_hora, alarme, bloqueio, falhas, evento, cod_evento, cod_invalido
   );
endinterface

// File: rtl/tratador_eventos.sv
// Event handler: turns terminal codes of the upstream FSM into timed acao/hora/alarm
// indications, counts consecutive failures and locks out after MAX_FALHAS of them.
module tratador_eventos #(
   parameter int T_PULSO    = 8,
   parameter int T_BLOQ     = 16,
   parameter int MAX_FALHAS = 3
) (
   input  logic               clk,
   input  logic               res,
   tratador_eventos_if.slave  bus
);
   localparam int T_MAX = (T_PULSO > T_BLOQ) ? T_PULSO : T_BLOQ;
   localparam int CW    = $clog2(T_MAX + 1);

   typedef enum logic [2:0] {
      OCIOSO     = 3'd0,
      ACAO_ATIVA = 3'd1,
      HORA_ATIVA = 3'd2,
      ALARME     = 3'd3,
      BLOQUEIO   = 3'd4
   } fsm_t;

   fsm_t          state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [3:0]    est_q;
   logic [2:0]    falhas_reg, falhas_next, falhas_inc;
   logic [1:0]    cod_reg, cod_next;
   logic          evento_reg, evento_next;
   logic          invalido_reg;
   logic          led_acao_reg, led_acao_next;
   logic          led_hora_reg, led_hora_next;
   logic          alarme_reg, alarme_next;
   logic          bloqueio_reg, bloqueio_next;
   logic          terminal, invalido, entrada;

   assign terminal   = bus.estado inside {4'b1000, 4'b1001, 4'b1010};
   assign invalido   = bus.estado inside {4'b0110, 4'b0111, [4'b1011:4'b1111]};
   assign entrada    = terminal && (bus.estado != est_q);
   assign falhas_inc = (falhas_reg == 3'd7) ? 3'd7 : falhas_reg + 3'd1;

   // State register plus the registered copies of every output
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_reg    <= OCIOSO;
         cnt_reg      <= '0;
         est_q        <= 4'b0000;
         falhas_reg   <= 3'b000;
         cod_reg      <= 2'b00;
         evento_reg   <= 1'b0;
         invalido_reg <= 1'b0;
         led_acao_reg <= 1'b0;
         led_hora_reg <= 1'b0;
         alarme_reg   <= 1'b0;
         bloqueio_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         est_q        <= bus.estado;
         falhas_reg   <= falhas_next;
         cod_reg      <= cod_next;
         evento_reg   <= evento_next;
         invalido_reg <= invalido_reg | invalido;
         led_acao_reg <= led_acao_next;
         led_hora_reg <= led_hora_next;
         alarme_reg   <= alarme_next;
         bloqueio_reg <= bloqueio_next;
      end
   end

   // Entries are only honoured in OCIOSO; an active indication ignores them until expiry
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      falhas_next = falhas_reg;
      cod_next    = cod_reg;
      evento_next = 1'b0;
      case (state_reg)
         OCIOSO: begin
            if (entrada) begin
               evento_next = 1'b1;
               case (bus.estado)
                  4'b1001: begin
                     state_next  = ACAO_ATIVA;
                     cnt_next    = CW'(T_PULSO);
                     falhas_next = 3'd0;
                     cod_next    = 2'b01;
                  end
                  4'b1010: begin
                     state_next  = HORA_ATIVA;
                     cnt_next    = CW'(T_PULSO);
                     falhas_next = 3'd0;
                     cod_next    = 2'b10;
                  end
                  default: begin
                     falhas_next = falhas_inc;
                     cod_next    = 2'b11;
                     if (32'(falhas_inc) >= MAX_FALHAS) begin
                        state_next = BLOQUEIO;
                        cnt_next   = CW'(T_BLOQ);
                     end else begin
                        state_next = ALARME;
                        cnt_next   = CW'(T_PULSO);
                     end
                  end
               endcase
            end
         end
         default: begin
            if (cnt_reg <= CW'(1)) begin
               state_next = OCIOSO;
               cnt_next   = '0;
               if (state_reg == BLOQUEIO)
                  falhas_next = 3'd0;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
      endcase
   end

   // Decoded from the next state so the registered lamps line up with the state itself
   always_comb begin
      led_acao_next = (state_next == ACAO_ATIVA);
      led_hora_next = (state_next == HORA_ATIVA);
      alarme_next   = (state_next == ALARME) || (state_next == BLOQUEIO);
      bloqueio_next = (state_next == BLOQUEIO);
   end

   assign bus.led_acao     = led_acao_reg;
   assign bus.led_hora     = led_hora_reg;
   assign bus.alarme       = alarme_reg;
   assign bus.bloqueio     = bloqueio_reg;
   assign bus.falhas       = falhas_reg;
   assign bus.evento       = evento_reg;
   assign bus.cod_evento   = cod_reg;
   assign bus.cod_invalido = invalido_reg;
endmodule

// File: tb/tb_tratador_eventos.sv
// Bench for tratador_eventos: directed scenarios then random codes and resets, each edge
// checked against a timeline model (indication occupies edges [start, busy_end)).
module tb_tratador_eventos;
   localparam int T_PULSO    = 8;
   localparam int T_BLOQ     = 16;
   localparam int MAX_FALHAS = 3;

   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   tratador_eventos_if bus ();

   tratador_eventos #(
      .T_PULSO(T_PULSO), .T_BLOQ(T_BLOQ), .MAX_FALHAS(MAX_FALHAS)
   ) dut (
      .clk(clk),
      .res(res),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: kind 0 none, 1 acao, 2 hora, 3 alarm, 4 lockout
   int edge_n   = 0;
   int busy_end = -1;
   int start_e  = 0;
   int kind     = 0;
   int m_falhas = 0;
   int m_cod    = 0;
   int m_inval  = 0;
   int m_evento = 0;
   int prev     = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
      end
   endtask

   task automatic model_reset();
      busy_end = -1;
      kind     = 0;
      m_falhas = 0;
      m_cod    = 0;
      m_inval  = 0;
      m_evento = 0;
      prev     = 0;
   endtask

   task automatic model_edge(input int e);
      m_evento = 0;
      if (kind == 4 && edge_n == busy_end)
         m_falhas = 0;
      if (e >= 8 && e <= 10 && e != prev && edge_n > busy_end) begin
         m_evento = 1;
         start_e  = edge_n;
         if (e == 9) begin
            kind = 1; m_falhas = 0; m_cod = 1; busy_end = edge_n + T_PULSO;
         end else if (e == 10) begin
            kind = 2; m_falhas = 0; m_cod = 2; busy_end = edge_n + T_PULSO;
         end else begin
            m_falhas = (m_falhas == 7) ? 7 : m_falhas + 1;
            m_cod    = 3;
            if (m_falhas >= MAX_FALHAS) begin
               kind = 4; busy_end = edge_n + T_BLOQ;
            end else begin
               kind = 3; busy_end = edge_n + T_PULSO;
            end
         end
      end
      if (e == 6 || e == 7 || e >= 11)
         m_inval = 1;
      prev = e;
   endtask

   task automatic check_all();
      int act;
      act = (kind != 0 && edge_n >= start_e && edge_n < busy_end) ? 1 : 0;
      check("led_acao", int'(bus.led_acao), (act == 1 && kind == 1) ? 1 : 0);
      check("led_hora", int'(bus.led_hora), (act == 1 && kind == 2) ? 1 : 0);
      check("alarme", int'(bus.alarme), (act == 1 && kind >= 3) ? 1 : 0);
      check("bloqueio", int'(bus.bloqueio), (act == 1 && kind == 4) ? 1 : 0);
      check("falhas", int'(bus.falhas), m_falhas);
      check("evento", int'(bus.evento), m_evento);
      check("cod_evento", int'(bus.cod_evento), m_cod);
      check("cod_invalido", int'(bus.cod_invalido), m_inval);
   endtask

   task automatic edge_check(input int e);
      @(posedge clk);
      model_edge(e);
      #1;
      check_all();
      if (m_evento == 1)
         $display("[TB] edge %0d estado=%04b accepted cod=%0d falhas=%0d", edge_n, e[3:0], m_cod, m_falhas);
      edge_n++;
   endtask

   task automatic step(input int e);
      @(negedge clk);
      bus.estado = e[3:0];
      edge_check(e);
   endtask

   task automatic hold(input int e, input int n);
      for (int k = 0; k < n; k++) step(e);
   endtask

   // Reset lands mid-cycle and is checked before any clock edge can act
   task automatic apply_reset(input int e_release);
      @(posedge clk);
      #3;
      res = 1'b0;
      #1;
      check("rst_led_acao", int'(bus.led_acao), 0);
      check("rst_led_hora", int'(bus.led_hora), 0);
      check("rst_alarme", int'(bus.alarme), 0);
      check("rst_bloqueio", int'(bus.bloqueio), 0);
      check("rst_falhas", int'(bus.falhas), 0);
      check("rst_evento", int'(bus.evento), 0);
      check("rst_cod_evento", int'(bus.cod_evento), 0);
      check("rst_cod_invalido", int'(bus.cod_invalido), 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.estado = e_release[3:0];
      res = 1'b1;
      $display("[TB] reset released with estado=%04b", e_release[3:0]);
      edge_check(e_release);
   endtask

   function automatic int pick_code();
      int r;
      int r2;
      r = int'($urandom_range(0, 99));
      if (r < 25) return 8;
      if (r < 45) return 9;
      if (r < 60) return 10;
      if (r < 62) begin
         r2 = int'($urandom_range(0, 6));
         return (r2 < 2) ? 6 + r2 : 9 + r2;
      end
      return int'($urandom_range(0, 5));
   endfunction

   initial begin
      int cur;
      bus.estado = 4'b0000;
      #2;
      apply_reset(0);

      // single acao, held code must not retrigger
      hold(1, 2); hold(9, 12); hold(0, 2);
      // three failures into lockout
      hold(8, 1); hold(0, 9); hold(8, 1); hold(0, 9); hold(8, 1); hold(0, 18);
      // two failures then hora clears the count
      hold(8, 1); hold(0, 9); hold(8, 1); hold(0, 9); hold(10, 10); hold(0, 2);
      // fals during acao is dropped
      hold(9, 3); hold(8, 8); hold(0, 2);
      // invalid code, then reset in the middle of a lockout
      hold(12, 1); hold(0, 2);
      hold(8, 1); hold(0, 9); hold(8, 1); hold(0, 9); hold(8, 1); hold(0, 5);
      apply_reset(0);
      // terminal code present at release counts as an entry
      apply_reset(9);
      hold(9, 10); hold(0, 2);

      cur = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            cur = pick_code();
            apply_reset(cur);
         end else begin
            if ($urandom_range(0, 99) >= 70)
               cur = pick_code();
            step(cur);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/tratador_eventos.md
TRATADOR_EVENTOS -- requirements
Module: tratador_eventos

Interface
REQ-001 The module SHALL have parameter T_PULSO, default 8, giving the number of cycles the acao/hora/alarme indication is held (minimum 1).
REQ-002 The module SHALL have parameter T_BLOQ, default 16, giving the number of cycles the lockout is held (minimum 1).
REQ-003 The module SHALL have parameter MAX_FALHAS, default 3, giving the failure count that triggers lockout (range 1..7).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 res  input  1  reset, asynchronous and active-low.
REQ-006 estado  input  4  state code from the upstream code-sequence FSM: 0000 inic, 0001-0101 est1-est5, 1000 fals, 1001 acao, 1010 hora.
REQ-007 led_acao  output  1  high while an acao indication is active.
REQ-008 led_hora  output  1  high while a hora indication is active.
REQ-009 alarme  output  1  high during a failure indication or lockout.
REQ-010 bloqueio  output  1  high during lockout.
REQ-011 falhas  output  3  consecutive-failure count.
REQ-012 evento  output  1  one-cycle pulse per accepted terminal event.
REQ-013 cod_evento  output  2  code of the last accepted event: 00 none, 01 acao, 10 hora, 11 fals.
REQ-014 cod_invalido  output  1  sticky flag: an undefined estado code was sampled.

Function
REQ-015 The block SHALL register estado into est_q on every clock edge.
REQ-016 An "entry" SHALL be defined as estado being in {1000, 1001, 1010} and estado != est_q at the sampling edge; a held code SHALL NOT re-trigger.
REQ-017 The FSM SHALL have states OCIOSO, ACAO_ATIVA, HORA_ATIVA, ALARME and BLOQUEIO, and a down-counter of ceil(log2(max(T_PULSO,T_BLOQ)+1)) bits.
REQ-018 In OCIOSO, entry of 1001 SHALL move to ACAO_ATIVA, load the counter with T_PULSO and clear falhas to 0.
REQ-019 In OCIOSO, entry of 1010 SHALL move to HORA_ATIVA, load the counter with T_PULSO and clear falhas to 0.
REQ-020 In OCIOSO, entry of 1000 SHALL increment falhas, saturating at 7.
REQ-021 After that increment, if the new falhas >= MAX_FALHAS, the FSM SHALL move to BLOQUEIO and load the counter with T_BLOQ; otherwise it SHALL move to ALARME and load the counter with T_PULSO.
REQ-022 Outputs SHALL be registered: led_acao=1 in ACAO_ATIVA, led_hora=1 in HORA_ATIVA, alarme=1 in ALARME or BLOQUEIO, bloqueio=1 in BLOQUEIO; all are 0 in every other state.
REQ-023 An indication SHALL start in the cycle after the sampling edge of the entry and last exactly T_PULSO cycles (T_BLOQ for BLOQUEIO); the FSM SHALL then return to OCIOSO.
REQ-024 On BLOQUEIO expiry the FSM SHALL clear falhas to 0.
REQ-025 Entries sampled in any state other than OCIOSO SHALL be dropped: no evento, no falhas change, no cod_evento change.
REQ-026 An entry sampled on the same edge as counter expiry SHALL be dropped.
REQ-027 evento SHALL pulse high for exactly one cycle, coincident with the first cycle of the indication, for each accepted entry only.
REQ-028 cod_evento SHALL update in that same cycle and hold its value until the next accepted entry.
REQ-029 Sampling estado in {0110, 0111, 1011-1111} SHALL set cod_invalido to 1 until reset; the FSM SHALL otherwise ignore that code.
REQ-030 Codes 0000-0101 SHALL cause no action.

Reset
REQ-031 While res=0, asynchronously: FSM=OCIOSO, counter=0, est_q=0000, falhas=000, cod_evento=00, and led_acao, led_hora, alarme, bloqueio, evento, cod_invalido all 0.
REQ-032 Reset asserted mid-indication or mid-lockout SHALL abort it immediately, with no residual pulse after release.
REQ-033 If estado is already a terminal code at reset release, the first sampling edge SHALL count as an entry.

Verification
REQ-034 Defaults; estado 0000->0001->1001 held -> evento pulse once, cod_evento=01, led_acao high exactly 8 cycles, then 0; no retrigger while 1001 held.
REQ-035 Sequence 1000,0000,1000,0000,1000, each accepted while OCIOSO -> falhas 1,2,3; alarme for 8 cycles on the first two; then bloqueio=alarme=1 for 16 cycles; then falhas=0.
REQ-036 Two fals, then 1010 -> falhas cleared to 0, led_hora high 8 cycles, cod_evento=10.
REQ-037 1001 accepted, then 1000 entered 3 cycles later -> fals dropped: falhas unchanged, single evento pulse.
REQ-038 estado=1100 for 1 cycle -> cod_invalido=1 and stays 1; FSM stays OCIOSO; res low mid-BLOQUEIO -> all outputs 0 immediately.
